// File: rtl/uart_rx_deser_cfg.sv
// uart_rx_deser_cfg: runtime-configurable UART receive deserialiser.
// Supports 5..MAX_WORD_WIDTH data bits, none/even/odd parity, and 1 or 2 stop bits.
// A registered holding stage presents each word with its parity/frame/break status.
// Optional feature macro: UART_RX_MAJORITY_EN. When defined, each bit is the 2-of-3 majority
// of the synced line on the ticks where tick_ctr is 2, 1 and 0. When undefined, one sample
// is taken at tick_ctr==0.
module uart_rx_deser_cfg #(
  parameter int MAX_WORD_WIDTH = 8,
  parameter int OVERSAMPLING   = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                tick_i,
  input  logic                                din_i,
  input  logic [$clog2(MAX_WORD_WIDTH+1)-1:0] cfg_word_len_i,
  input  logic [1:0]                          cfg_parity_i,
  input  logic                                cfg_stop2_i,
  output logic [MAX_WORD_WIDTH-1:0]           dout_o,
  output logic                                dout_valid_o,
  input  logic                                dout_ready_i,
  output logic                                parity_err_o,
  output logic                                frame_err_o,
  output logic                                break_det_o,
  output logic                                overrun_o,
  output logic                                active_o
);

  localparam int WLW = $clog2(MAX_WORD_WIDTH + 1);
  localparam int TCW = $clog2(OVERSAMPLING);

  localparam logic [TCW-1:0] TC_ZERO = {TCW{1'b0}};
  localparam logic [TCW-1:0] TC_ONE  = TCW'(1);
  localparam logic [TCW-1:0] TC_HALF = TCW'(OVERSAMPLING / 2 - 1);
  localparam logic [TCW-1:0] TC_FULL = TCW'(OVERSAMPLING - 1);
  localparam logic [WLW-1:0] WL_ZERO = {WLW{1'b0}};
  localparam logic [WLW-1:0] WL_ONE  = WLW'(1);
  localparam logic [MAX_WORD_WIDTH-1:0] WORD_ZERO = {MAX_WORD_WIDTH{1'b0}};
  localparam logic [MAX_WORD_WIDTH-1:0] WORD_LSB  = MAX_WORD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP1     = 3'd4,
    S_STOP2     = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_e;

  // Expected parity bit: even parity repeats the data XOR, odd parity inverts it.
  function automatic logic exp_parity(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

  state_e                    state_q;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic [TCW-1:0]            tick_ctr_q;
  logic [WLW-1:0]            bit_cnt_q;
  logic [WLW-1:0]            wl_q;
  logic                      par_en_q;
  logic                      par_odd_q;
  logic                      stop2_q;
  logic [MAX_WORD_WIDTH-1:0] shift_q;
  logic                      par_acc_q;
  logic                      perr_f_q;
  logic                      ferr_f_q;
  logic                      brk_f_q;
  logic [MAX_WORD_WIDTH-1:0] dout_q;
  logic                      dout_valid_q;
  logic                      parity_err_q;
  logic                      frame_err_q;
  logic                      break_det_q;
  logic                      overrun_q;

  logic                      din_s;
  logic                      sample_s;
  logic                      mid_s;
  logic                      bit_state_s;
  logic                      complete_s;
  logic                      fin_ferr_s;
  logic                      fin_brk_s;
  logic [MAX_WORD_WIDTH-1:0] bit_mask_s;

  // Metastability chain for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  // 2-of-3 vote over three consecutive samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two early votes (tick_ctr 2 and 1) of every bit period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      maj_q <= 2'b11;
    end else if (tick_i && bit_state_s) begin
      if (tick_ctr_q == TCW'(2)) begin
        maj_q[1] <= din_s;
      end else if (tick_ctr_q == TC_ONE) begin
        maj_q[0] <= din_s;
      end
    end
  end

  assign sample_s = maj3(maj_q[1], maj_q[0], din_s);
`else
  assign sample_s = din_s;
`endif

  assign bit_state_s = (state_q inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2});
  assign mid_s       = tick_i && (tick_ctr_q == TC_ZERO);
  assign fin_ferr_s  = ferr_f_q | ~sample_s;
  assign fin_brk_s   = brk_f_q & ~sample_s;
  assign complete_s  = mid_s && (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
  assign bit_mask_s  = WORD_LSB << bit_cnt_q;

  // Frame FSM plus holding stage: bit timing, shifting, error tracking, handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tick_ctr_q   <= TC_ZERO;
      bit_cnt_q    <= WL_ZERO;
      wl_q         <= WL_ZERO;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      shift_q      <= WORD_ZERO;
      par_acc_q    <= 1'b0;
      perr_f_q     <= 1'b0;
      ferr_f_q     <= 1'b0;
      brk_f_q      <= 1'b0;
      dout_q       <= WORD_ZERO;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (tick_i && bit_state_s) begin
        tick_ctr_q <= (tick_ctr_q == TC_ZERO) ? TC_FULL : (tick_ctr_q - TC_ONE);
      end

      case (state_q)
        S_IDLE: begin
          if (tick_i && !din_s) begin
            state_q    <= S_START;
            tick_ctr_q <= TC_HALF;
            wl_q       <= cfg_word_len_i;
            par_en_q   <= cfg_parity_i[0] ^ cfg_parity_i[1];
            par_odd_q  <= cfg_parity_i[1];
            stop2_q    <= cfg_stop2_i;
            bit_cnt_q  <= WL_ZERO;
            shift_q    <= WORD_ZERO;
            par_acc_q  <= 1'b0;
            perr_f_q   <= 1'b0;
            ferr_f_q   <= 1'b0;
            brk_f_q    <= 1'b1;
          end
        end
        S_START: begin
          if (mid_s) begin
            state_q <= sample_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (mid_s) begin
            if (sample_s) begin
              shift_q <= shift_q | bit_mask_s;
            end
            par_acc_q <= par_acc_q ^ sample_s;
            brk_f_q   <= brk_f_q & ~sample_s;
            if (bit_cnt_q == (wl_q - WL_ONE)) begin
              state_q <= par_en_q ? S_PARITY : S_STOP1;
            end else begin
              bit_cnt_q <= bit_cnt_q + WL_ONE;
            end
          end
        end
        S_PARITY: begin
          if (mid_s) begin
            perr_f_q <= (sample_s != exp_parity(par_acc_q, par_odd_q));
            brk_f_q  <= brk_f_q & ~sample_s;
            state_q  <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (mid_s) begin
            if (stop2_q) begin
              ferr_f_q <= fin_ferr_s;
              brk_f_q  <= fin_brk_s;
              state_q  <= S_STOP2;
            end else begin
              state_q <= fin_brk_s ? S_WAIT_IDLE : S_IDLE;
            end
          end
        end
        S_STOP2: begin
          if (mid_s) begin
            state_q <= fin_brk_s ? S_WAIT_IDLE : S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (din_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Holding stage: a completed word loads if the slot is free or being drained,
      // otherwise it is dropped and overrun pulses.
      overrun_q <= 1'b0;
      if (complete_s) begin
        if (!dout_valid_q || dout_ready_i) begin
          dout_q       <= shift_q;
          dout_valid_q <= 1'b1;
          parity_err_q <= perr_f_q;
          frame_err_q  <= fin_ferr_s;
          break_det_q  <= fin_brk_s;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready_i) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign break_det_o  = break_det_q;
  assign overrun_o    = overrun_q;
  assign active_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Directed bench for uart_rx_deser_cfg: 16x oversampling, tick every other clock.
module tb_uart_rx_deser_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       din = 1'b1;
  logic [3:0] cfg_wl = 4'd8;
  logic [1:0] cfg_par = 2'b00;
  logic       cfg_st2 = 1'b0;
  logic       rdy = 1'b1;
  logic [7:0] dout;
  logic       dvalid, perr, ferr, brk, ovr, active;

  int total = 0;
  int bad = 0;

  int         acc_cnt = 0;
  int         ovr_cnt = 0;
  int         vhi_cnt = 0;
  int         act_cnt = 0;
  logic [7:0] acc_word = 8'h00;
  logic       acc_perr = 1'b0;
  logic       acc_ferr = 1'b0;
  logic       acc_brk = 1'b0;
  int         a0, o0, v0, c0;
  logic [7:0] exp_glitch;

  uart_rx_deser_cfg #(.MAX_WORD_WIDTH(8), .OVERSAMPLING(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .din_i(din),
    .cfg_word_len_i(cfg_wl), .cfg_parity_i(cfg_par), .cfg_stop2_i(cfg_st2),
    .dout_o(dout), .dout_valid_o(dvalid), .dout_ready_i(rdy),
    .parity_err_o(perr), .frame_err_o(ferr), .break_det_o(brk),
    .overrun_o(ovr), .active_o(active)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 tick = ~tick;
    end
  end

  always @(negedge clk) begin
    if (dvalid) vhi_cnt++;
    if (dvalid && rdy) begin
      acc_cnt++;
      acc_word = dout;
      acc_perr = perr;
      acc_ferr = ferr;
      acc_brk  = brk;
    end
    if (ovr) ovr_cnt++;
    if (active) act_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    wait_ticks(16);
    #1;
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    wait_ticks(n);
    #1;
  endtask

  task automatic snap();
    a0 = acc_cnt; o0 = ovr_cnt; v0 = vhi_cnt; c0 = act_cnt;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [3:0] wl, input logic [1:0] par,
                            input logic st2, input logic flip, input logic scramble, input int gbit);
    logic p;
    cfg_wl = wl; cfg_par = par; cfg_st2 = st2;
    wait_ticks(1);
    #1;
    send_bit(1'b0);
    if (scramble) begin
      cfg_wl = 4'd5; cfg_par = 2'b10; cfg_st2 = 1'b1;
    end
    p = 1'b0;
    for (int i = 0; i < int'(wl); i++) begin
      p = p ^ data[i];
      if (i == gbit) begin
        din = 1'b1;
        wait_ticks(8);
        #1 din = 1'b0;
        wait_ticks(1);
        #1 din = 1'b1;
        wait_ticks(7);
        #1;
      end else begin
        send_bit(data[i]);
      end
    end
    if (par == 2'b01) send_bit(p ^ flip);
    else if (par == 2'b10) send_bit(~p ^ flip);
    send_bit(1'b1);
    if (st2) send_bit(1'b1);
    cfg_wl = wl; cfg_par = par; cfg_st2 = st2;
  endtask

  initial begin
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'hFF;
`else
    exp_glitch = 8'hF7;
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dvalid), 32'h0);
    check("rst_perr", 32'(perr), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_brk", 32'(brk), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // 8N1 0xA5 with ready held high
    snap();
    send_frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t1_count", 32'(acc_cnt - a0), 32'd1);
    check("t1_word", 32'(acc_word), 32'hA5);
    check("t1_perr", 32'(acc_perr), 32'h0);
    check("t1_ferr", 32'(acc_ferr), 32'h0);
    check("t1_brk", 32'(acc_brk), 32'h0);
    check("t1_valid_cycles", 32'(vhi_cnt - v0), 32'd1);
    check("t1_overrun", 32'(ovr_cnt - o0), 32'd0);

    // 7E1 0x41 with inverted parity bit
    snap();
    send_frame(8'h41, 4'd7, 2'b01, 1'b0, 1'b1, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t2a_count", 32'(acc_cnt - a0), 32'd1);
    check("t2a_word", 32'(acc_word), 32'h41);
    check("t2a_perr", 32'(acc_perr), 32'h1);
    check("t2a_ferr", 32'(acc_ferr), 32'h0);

    // 5O2 0x15 with correct parity
    snap();
    send_frame(8'h15, 4'd5, 2'b10, 1'b1, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t2b_count", 32'(acc_cnt - a0), 32'd1);
    check("t2b_word", 32'(acc_word), 32'h15);
    check("t2b_perr", 32'(acc_perr), 32'h0);
    check("t2b_ferr", 32'(acc_ferr), 32'h0);
    check("t2b_brk", 32'(acc_brk), 32'h0);

    // 8N1 0xC3 with cfg changed right after the start bit
    snap();
    send_frame(8'hC3, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    @(negedge clk);
    check("cfg_count", 32'(acc_cnt - a0), 32'd1);
    check("cfg_word", 32'(acc_word), 32'hC3);
    check("cfg_perr", 32'(acc_perr), 32'h0);
    check("cfg_ferr", 32'(acc_ferr), 32'h0);

    // False start: line low for 4 ticks
    snap();
    wait_ticks(1);
    #1 din = 1'b0;
    wait_ticks(4);
    #1 din = 1'b1;
    idle(30);
    @(negedge clk);
    check("t3_active_seen", 32'(act_cnt > c0), 32'h1);
    check("t3_active_now", 32'(active), 32'h0);
    check("t3_count", 32'(acc_cnt - a0), 32'd0);
    check("t3_valid_cycles", 32'(vhi_cnt - v0), 32'd0);

    // Overrun: ready low, two frames
    rdy = 1'b0;
    snap();
    send_frame(8'h55, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t4_valid1", 32'(dvalid), 32'h1);
    check("t4_dout1", 32'(dout), 32'h55);
    check("t4_ovr1", 32'(ovr_cnt - o0), 32'd0);
    send_frame(8'h33, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t4_ovr2", 32'(ovr_cnt - o0), 32'd1);
    check("t4_dout2", 32'(dout), 32'h55);
    check("t4_valid2", 32'(dvalid), 32'h1);
    check("t4_count0", 32'(acc_cnt - a0), 32'd0);
    @(posedge clk);
    #1 rdy = 1'b1;
    idle(40);
    @(negedge clk);
    check("t4_count1", 32'(acc_cnt - a0), 32'd1);
    check("t4_accepted", 32'(acc_word), 32'h55);
    check("t4_valid3", 32'(dvalid), 32'h0);

    // Break: 20 bit times low, then a normal frame
    cfg_wl = 4'd8; cfg_par = 2'b00; cfg_st2 = 1'b0;
    snap();
    wait_ticks(1);
    #1 din = 1'b0;
    wait_ticks(320);
    @(negedge clk);
    check("t5_count", 32'(acc_cnt - a0), 32'd1);
    check("t5_word", 32'(acc_word), 32'h00);
    check("t5_brk", 32'(acc_brk), 32'h1);
    check("t5_ferr", 32'(acc_ferr), 32'h1);
    check("t5_active_low", 32'(active), 32'h1);
    wait_ticks(1);
    #1;
    idle(40);
    @(negedge clk);
    check("t5_active_idle", 32'(active), 32'h0);
    check("t5_count_idle", 32'(acc_cnt - a0), 32'd1);
    send_frame(8'h12, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t5_count2", 32'(acc_cnt - a0), 32'd2);
    check("t5_word2", 32'(acc_word), 32'h12);
    check("t5_brk2", 32'(acc_brk), 32'h0);
    check("t5_ferr2", 32'(acc_ferr), 32'h0);
    check("t5_perr2", 32'(acc_perr), 32'h0);

    // One-tick glitch at the mid sample of data bit 3
    snap();
    send_frame(8'hFF, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 3);
    idle(4);
    @(negedge clk);
    check("t6_count", 32'(acc_cnt - a0), 32'd1);
    check("t6_word", 32'(acc_word), 32'(exp_glitch));

    // Reset in the middle of the data bits
    wait_ticks(1);
    #1 din = 1'b0;
    wait_ticks(16);
    #1;
    wait_ticks(40);
    @(negedge clk);
    check("t7_active_pre", 32'(active), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    din = 1'b1;
    @(negedge clk);
    check("t7_dout", 32'(dout), 32'h0);
    check("t7_valid", 32'(dvalid), 32'h0);
    check("t7_active", 32'(active), 32'h0);
    check("t7_flags", 32'({perr, ferr, brk, ovr}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    snap();
    send_frame(8'h5A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    @(negedge clk);
    check("t7_count", 32'(acc_cnt - a0), 32'd1);
    check("t7_word", 32'(acc_word), 32'h5A);
    check("t7_ferr", 32'(acc_ferr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
